uart_bus_ctrl: RTL

Sequential bus controller for the CPLD UART on the shared 8-bit RAM1/UART data bus. It sits directly upstream of the serial connection stage and replaces level-driven strobes with a clocked read/write cycle engine. The host side sees a 4-entry TX FIFO and a single-byte RX holding register. The bus side generates `rdn`/`wrn` pulses, drives or releases the bus, and paces transfers from the synchronized `tbre`, `tsre` and `data_ready` status lines.

---
 rtl/uart_bus_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_bus_ctrl.sv
// Clocked read/write cycle engine for the CPLD UART on the shared RAM1/UART bus.
// Host side: small TX FIFO plus a one-byte RX holding register with sticky overrun.
module uart_bus_ctrl #(
  parameter int STROBE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ack,
  output logic       o_overrun,
  output logic       o_busy,
  output logic [7:0] o_bus_dout,
  output logic       o_bus_oe,
  input  logic [7:0] i_bus_din,
  output logic       o_rdn,
  output logic       o_wrn,
  input  logic       i_tbre,
  input  logic       i_tsre,
  input  logic       i_data_ready,
  output logic       o_ram1_en
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] STB_LAST = 3'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WR_GUARD, RD_STROBE, RD_GUARD
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_tbre_sync, r_tsre_sync, r_dr_sync;
  logic        w_tbre_s, w_tsre_s, w_data_ready_s;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic        w_push, w_pop;

  logic        r_rdn, r_wrn, r_bus_oe, r_rx_valid, r_overrun, r_busy, r_ram1_en;
  logic [7:0]  r_bus_dout, r_rx_data;

  // Status lines are asynchronous to clk; only the second flop is trusted.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tbre_sync <= '0;
      r_tsre_sync <= '0;
      r_dr_sync   <= '0;
    end else begin
      r_tbre_sync <= {r_tbre_sync[0], i_tbre};
      r_tsre_sync <= {r_tsre_sync[0], i_tsre};
      r_dr_sync   <= {r_dr_sync[0], i_data_ready};
    end
  end

  assign w_tbre_s       = r_tbre_sync[1];
  assign w_tsre_s       = r_tsre_sync[1];
  assign w_data_ready_s = r_dr_sync[1];

  assign o_tx_ready = (r_count != CW'(FIFO_DEPTH));
  assign w_push     = i_tx_valid && o_tx_ready;
  // Reads win over writes when both are pending in IDLE.
  assign w_pop      = (r_state == IDLE) && !w_data_ready_s && (r_count != '0) &&
                      w_tbre_s && w_tsre_s;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rdn      <= 1'b1;
      r_wrn      <= 1'b1;
      r_bus_oe   <= 1'b0;
      r_bus_dout <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
      r_ram1_en  <= 1'b1;
    end else begin
      r_ram1_en <= 1'b1;
      // A capture in RD_STROBE below overrides this clear on the same edge.
      if (i_rx_ack && r_rx_valid) r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_data_ready_s) begin
            r_state <= RD_STROBE;
            r_rdn   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_pop) begin
            r_bus_dout <= r_mem[r_rd_ptr];
            r_bus_oe   <= 1'b1;
            r_state    <= WR_SETUP;
            r_busy     <= 1'b1;
          end
        end
        WR_SETUP: begin
          r_wrn   <= 1'b0;
          r_cnt   <= '0;
          r_state <= WR_STROBE;
        end
        WR_STROBE: begin
          if (r_cnt == STB_LAST) begin
            r_wrn   <= 1'b1;
            r_state <= WR_HOLD;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        WR_HOLD: begin
          r_bus_oe <= 1'b0;
          r_cnt    <= '0;
          r_state  <= WR_GUARD;
        end
        RD_STROBE: begin
          if (r_cnt == STB_LAST) begin
            r_rdn   <= 1'b1;
            r_cnt   <= '0;
            r_state <= RD_GUARD;
            if (!r_rx_valid || i_rx_ack) begin
              r_rx_data  <= i_bus_din;
              r_rx_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        WR_GUARD, RD_GUARD: begin
          // Two cycles so the synchronized status reflects the finished access.
          if (r_cnt == 3'd1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rdn    <= 1'b1;
          r_wrn    <= 1'b1;
          r_bus_oe <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdn      = r_rdn;
  assign o_wrn      = r_wrn;
  assign o_bus_oe   = r_bus_oe;
  assign o_bus_dout = r_bus_dout;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_overrun  = r_overrun;
  assign o_busy     = r_busy;
  assign o_ram1_en  = r_ram1_en;

endmodule
